// File: rtl/packer_fsm.sv
// Packs a stream of 32-byte beats into 160-byte words of up to five beats.
// Beats are MSB-first and right-aligned: the newest beat of a word is at [255:0].
module packer_fsm (
    input  logic          clk,
    input  logic          reset,
    input  logic          val,
    input  logic          sop,
    input  logic          eop,
    input  logic [7:0]    vbc,
    input  logic [255:0]  data,
    output logic          ready,
    output logic          o_val,
    output logic          o_sop,
    output logic          o_eop,
    output logic [7:0]    o_vbc,
    output logic [1279:0] o_data,
    input  logic          o_ready,
    output logic          o_err,
    output logic          idle
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t        state_reg;
    logic [1023:0] acc_reg;
    logic [2:0]    count_reg;
    logic          first_reg;
    logic          pend_reg;
    logic [7:0]    pend_vbc_reg;

    logic       out_free;
    logic       fire;
    logic       vbc_ok;
    logic       short_beat;
    logic       closes;
    logic       has_acc;
    logic [7:0] acc_vbc;
    logic [7:0] app_vbc;

    assign out_free   = !o_val || o_ready;
    // A sop+eop beat arriving mid-packet needs a second word slot, so it is
    // parked for one cycle and further beats are held off meanwhile.
    assign ready      = out_free && !pend_reg;
    assign fire       = val && ready;
    assign vbc_ok     = (vbc != 8'd0) && (vbc <= 8'd32);
    assign short_beat = (vbc != 8'd32);
    assign closes     = eop || short_beat;
    assign has_acc    = (count_reg != 3'd0);
    assign acc_vbc    = {count_reg, 5'b0};
    assign app_vbc    = acc_vbc + vbc;
    assign idle       = (state_reg == IDLE) && !has_acc && !o_val && !pend_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            count_reg    <= '0;
            first_reg    <= 1'b0;
            pend_reg     <= 1'b0;
            pend_vbc_reg <= '0;
            o_val        <= 1'b0;
            o_sop        <= 1'b0;
            o_eop        <= 1'b0;
            o_vbc        <= '0;
            o_data       <= '0;
            o_err        <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (o_val && o_ready)
                o_val <= 1'b0;

            if (pend_reg && out_free) begin
                o_val    <= 1'b1;
                o_data   <= {1024'b0, acc_reg[255:0]};
                o_vbc    <= pend_vbc_reg;
                o_sop    <= 1'b1;
                o_eop    <= 1'b1;
                pend_reg <= 1'b0;
                acc_reg  <= '0;
            end else if (fire) begin
                case (state_reg)
                    IDLE: begin
                        if (!sop || !vbc_ok) begin
                            o_err <= 1'b1;
                        end else if (closes) begin
                            o_val  <= 1'b1;
                            o_data <= {1024'b0, data};
                            o_vbc  <= vbc;
                            o_sop  <= 1'b1;
                            o_eop  <= 1'b1;
                            o_err  <= !eop;
                        end else begin
                            acc_reg   <= {768'b0, data};
                            count_reg <= 3'd1;
                            first_reg <= 1'b1;
                            state_reg <= PKT;
                        end
                    end
                    PKT: begin
                        if (!vbc_ok || sop) begin
                            // Abort: flush what was collected as the packet's last word.
                            o_err <= 1'b1;
                            if (has_acc) begin
                                o_val  <= 1'b1;
                                o_data <= {256'b0, acc_reg};
                                o_vbc  <= acc_vbc;
                                o_sop  <= first_reg;
                                o_eop  <= 1'b1;
                            end
                            acc_reg   <= '0;
                            count_reg <= '0;
                            first_reg <= 1'b0;
                            state_reg <= IDLE;
                            if (vbc_ok) begin
                                if (!closes) begin
                                    acc_reg   <= {768'b0, data};
                                    count_reg <= 3'd1;
                                    first_reg <= 1'b1;
                                    state_reg <= PKT;
                                end else if (has_acc) begin
                                    pend_reg     <= 1'b1;
                                    pend_vbc_reg <= vbc;
                                    acc_reg      <= {768'b0, data};
                                end else begin
                                    o_val  <= 1'b1;
                                    o_data <= {1024'b0, data};
                                    o_vbc  <= vbc;
                                    o_sop  <= 1'b1;
                                    o_eop  <= 1'b1;
                                end
                            end
                        end else if (closes || count_reg == 3'd4) begin
                            o_val     <= 1'b1;
                            o_data    <= {acc_reg, data};
                            o_vbc     <= app_vbc;
                            o_sop     <= first_reg;
                            o_eop     <= closes;
                            o_err     <= !eop && short_beat;
                            acc_reg   <= '0;
                            count_reg <= '0;
                            first_reg <= 1'b0;
                            state_reg <= closes ? IDLE : PKT;
                        end else begin
                            acc_reg   <= {acc_reg[767:0], data};
                            count_reg <= count_reg + 3'd1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
